// File: rtl/spi_sram_master.sv
// SPI mode-0 master for single-byte SRAM read/write frames (addr, cmd, data).
// Define SPI_MASTER_LOOPBACK_EN to add the lpbk port (receive path taps mosi).
module spi_sram_master #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 2,
   parameter int GAP     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
`ifdef SPI_MASTER_LOOPBACK_EN
   input  logic              lpbk,
`endif
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic              sclk,
   output logic              ss,
   output logic              mosi,
   input  logic              miso
);

   localparam int N  = ADDR_W + 1 + DATA_W;
   localparam int GL = 2 * GAP * CLK_DIV;
   localparam int HW = $clog2(CLK_DIV + 1);
   localparam int BW = $clog2(N + 1);
   localparam int GW = $clog2(GL + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, GAPS, DONE} state_t;

   state_t            state_q, state_d;
   logic [N-1:0]      sreg;
   logic [DATA_W-1:0] rx;
   logic              cmd;
   logic              sclk_q;
   logic [HW-1:0]     hcnt;
   logic [BW-1:0]     bcnt;
   logic [GW-1:0]     gcnt;
   logic              tog, fall, last, gend;
   logic              dphase, accept, rbit, upd;

   assign tog    = hcnt == HW'(CLK_DIV - 1);
   assign fall   = tog & sclk_q;
   assign last   = fall & (bcnt == BW'(N - 1));
   assign gend   = gcnt == GW'(GL - 1);
   assign dphase = bcnt > BW'(ADDR_W);
   assign accept = start & ((state_q == IDLE) | (state_q == DONE));
   assign sclk   = sclk_q;

`ifdef SPI_MASTER_LOOPBACK_EN
   assign rbit = lpbk ? mosi : miso;
   assign upd  = ~cmd | lpbk;
`else
   assign rbit = miso;
   assign upd  = ~cmd;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (last)  state_d = GAPS;
         GAPS:    if (gend)  state_d = DONE;
         DONE:    state_d = start ? SHIFT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ss   = 1'b1;
      busy = 1'b0;
      done = 1'b0;
      mosi = 1'b0;
      unique case (state_q)
         SHIFT: begin
            ss   = 1'b0;
            busy = 1'b1;
            mosi = sreg[N-1];
         end
         GAPS:    busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Read frames load zeros into the data slot so mosi idles low there.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sreg   <= '0;
         rx     <= '0;
         rdata  <= '0;
         cmd    <= 1'b0;
         sclk_q <= 1'b0;
         hcnt   <= '0;
         bcnt   <= '0;
         gcnt   <= '0;
      end else if (accept) begin
         sreg   <= {addr, rw, rw ? wdata : {DATA_W{1'b0}}};
         cmd    <= rw;
         sclk_q <= 1'b0;
         hcnt   <= '0;
         bcnt   <= '0;
         gcnt   <= '0;
      end else if (state_q == SHIFT) begin
         if (tog) begin
            hcnt   <= '0;
            sclk_q <= ~sclk_q;
            if (sclk_q) begin
               sreg <= {sreg[N-2:0], 1'b0};
               bcnt <= last ? '0 : bcnt + BW'(1);
            end else if (dphase) begin
               rx <= {rx[DATA_W-2:0], rbit};
            end
         end else begin
            hcnt <= hcnt + HW'(1);
         end
      end else if (state_q == GAPS) begin
         gcnt <= gend ? '0 : gcnt + GW'(1);
         if (gend && upd) rdata <= rx;
      end
   end

endmodule

// File: tb/tb_spi_sram_master.sv
// Bench for spi_sram_master: default instance plus a CLK_DIV=1/GAP=1 one,
// each with a mode-0 slave model and a frame-level reference model.
module tb_spi_sram_master;

   logic       clk = 1'b0;
   logic       rst;
   logic       start [2];
   logic       rw    [2];
   logic [7:0] addr  [2];
   logic [7:0] wdata [2];
   logic [7:0] rdata [2];
   logic       busy  [2];
   logic       done  [2];
   logic       sclk  [2];
   logic       ss    [2];
   logic       mosi  [2];
   logic       miso  [2];

   logic [7:0]  mdat   [2];
   logic [7:0]  exp_rd [2];
   logic [16:0] cap    [2];
   int          redge  [2];
   int          mhi    [2];
   logic        psclk  [2];
   logic        pmosi  [2];

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   spi_sram_master u_dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .rw(rw[0]),
      .addr(addr[0]), .wdata(wdata[0]), .busy(busy[0]),
      .done(done[0]), .rdata(rdata[0]), .sclk(sclk[0]),
      .ss(ss[0]), .mosi(mosi[0]), .miso(miso[0])
   );

   spi_sram_master #(.CLK_DIV(1), .GAP(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .rw(rw[1]),
      .addr(addr[1]), .wdata(wdata[1]), .busy(busy[1]),
      .done(done[1]), .rdata(rdata[1]), .sclk(sclk[1]),
      .ss(ss[1]), .mosi(mosi[1]), .miso(miso[1])
   );

   // Slave side: capture mosi on sclk rise, present miso for the next rise.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (ss[k]) begin
            redge[k] = 0;
         end else if (sclk[k] && !psclk[k]) begin
            cap[k]   = {cap[k][15:0], mosi[k]};
            redge[k] = redge[k] + 1;
         end
         if (sclk[k] && (mosi[k] !== pmosi[k])) mhi[k] = mhi[k] + 1;
         psclk[k] = sclk[k];
         pmosi[k] = mosi[k];
      end
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         miso[k] = 1'b0;
         if (redge[k] >= 9 && redge[k] < 17)
            miso[k] = mdat[k][3'(16 - redge[k])];
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic launch(input int k, input bit rwb, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] md);
      @(negedge clk);
      rw[k]    = rwb;
      addr[k]  = a;
      wdata[k] = d;
      mdat[k]  = md;
      start[k] = 1'b1;
      @(negedge clk);
   endtask

   // Called at the first ss-low sample; runs until done or a cycle budget.
   task automatic monitor(input int k, input bit rwb, input logic [7:0] a,
                          input logic [7:0] d, input logic [7:0] md,
                          input bit noise);
      int t, sl, m0, cd, gp;
      logic [16:0] ecap;
      cd   = (k == 0) ? 2 : 1;
      gp   = (k == 0) ? 2 : 1;
      ecap = {a, rwb, rwb ? d : 8'h00};
      m0   = mhi[k];
      t    = 0;
      sl   = 0;
      check("t1_busy", 32'(busy[k]), 1);
      check("t1_ss", 32'(ss[k]), 0);
      while (!done[k] && t < 300) begin
         if (!ss[k]) sl++;
         if (noise && t == 20) begin
            start[k] = 1'b1;
            addr[k]  = 8'($urandom);
         end
         if (noise && t == 21) start[k] = 1'b0;
         @(negedge clk);
         t++;
      end
      if (!rwb) exp_rd[k] = md;
      check("done_lat", t, 32'(2 * 17 * cd + 2 * gp * cd));
      check("ss_low", sl, 32'(2 * 17 * cd));
      check("done_busy", 32'(busy[k]), 0);
      check("rdata", 32'(rdata[k]), 32'(exp_rd[k]));
      check("mosi_bits", 32'(cap[k]), 32'(ecap));
      check("mosi_hold", mhi[k] - m0, 0);
   endtask

   initial begin
      logic [7:0] a, d, md;
      bit         rb;
      int         cnt;
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         start[k] = 1'b0; rw[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
         mdat[k] = '0; exp_rd[k] = '0; cap[k] = '0; redge[k] = 0;
         mhi[k] = 0; psclk[k] = 1'b0; pmosi[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("rst_ss", 32'(ss[k]), 1);
         check("rst_sclk", 32'(sclk[k]), 0);
         check("rst_mosi", 32'(mosi[k]), 0);
         check("rst_busy", 32'(busy[k]), 0);
         check("rst_done", 32'(done[k]), 0);
         check("rst_rdata", 32'(rdata[k]), 0);
      end
      rst = 1'b1;

      launch(0, 1'b1, 8'hA5, 8'h3C, 8'h00);
      start[0] = 1'b0;
      monitor(0, 1'b1, 8'hA5, 8'h3C, 8'h00, 1'b0);
      launch(0, 1'b0, 8'h12, 8'h77, 8'hC3);
      start[0] = 1'b0;
      monitor(0, 1'b0, 8'h12, 8'h77, 8'hC3, 1'b0);

      for (int i = 0; i < 6; i++) begin
         rb = 1'($urandom); a = 8'($urandom);
         d  = 8'($urandom); md = 8'($urandom);
         launch(0, rb, a, d, md);
         start[0] = 1'b0;
         monitor(0, rb, a, d, md, i == 5);
      end
      cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (!ss[0]) cnt++;
      end
      check("no_extra_frame", cnt, 0);

      rb = 1'b0; a = 8'($urandom); d = 8'($urandom); md = 8'($urandom);
      launch(0, rb, a, d, md);
      monitor(0, rb, a, d, md, 1'b0);
      @(negedge clk);
      check("b2b_ss", 32'(ss[0]), 0);
      start[0] = 1'b0;
      monitor(0, rb, a, d, md, 1'b0);

      for (int i = 0; i < 3; i++) begin
         rb = (i == 0) ? 1'b1 : 1'b0;
         a  = 8'($urandom); d = 8'($urandom); md = 8'($urandom);
         launch(1, rb, a, d, md);
         start[1] = 1'b0;
         monitor(1, rb, a, d, md, 1'b0);
      end

      launch(0, 1'b0, 8'h5A, 8'h00, 8'h96);
      start[0] = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_ss", 32'(ss[0]), 1);
      check("mid_rst_sclk", 32'(sclk[0]), 0);
      check("mid_rst_busy", 32'(busy[0]), 0);
      @(negedge clk);
      rst = 1'b1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      check("mid_rst_rdata", 32'(rdata[0]), 0);
      check("mid_rst_rdata1", 32'(rdata[1]), 0);
      cnt = 0;
      repeat (100) begin
         @(negedge clk);
         if (done[0]) cnt++;
      end
      check("mid_rst_nodone", cnt, 0);

      md = 8'($urandom);
      launch(0, 1'b0, 8'h3E, 8'h00, md);
      start[0] = 1'b0;
      monitor(0, 1'b0, 8'h3E, 8'h00, md, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/spi_sram_master.md
Name: spi_sram_master

Overview:
- SPI master that drives the SRAM-side SPI slave interface, issuing single-byte read and write transactions.
- Accepts a request from local logic and serialises it as one frame: address, command bit, data byte.
- Generates sclk, ss and mosi, samples miso during the read-data phase, and returns the read byte with a one-cycle done pulse.
- Sits between the host/test logic and the SPI pins of the SRAM slave.

Parameters:
- ADDR_W, 8, address bits per frame, sent MSB first.
- DATA_W, 8, data bits per frame, MSB first.
- CLK_DIV, 2, clk cycles per sclk half-period; minimum 1.
- GAP, 2, sclk periods that ss is held high after a frame before done.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only when busy=0.
- rw  input  1  1 = write, 0 = read; captured with start.
- addr  input  ADDR_W  target address; captured with start.
- wdata  input  DATA_W  write data; captured with start.
- busy  output  1  high from the cycle after accept until the done cycle (exclusive).
- done  output  1  one-cycle pulse at transaction end.
- rdata  output  DATA_W  last read byte; held until the next read completes.
- sclk  output  1  SPI clock, idle low (mode 0).
- ss  output  1  slave select, active low.
- mosi  output  1  serial data to slave.
- miso  input  1  serial data from slave.

Behaviour:
- Reset (async, rst=0): ss=1, sclk=0, mosi=0, busy=0, done=0, rdata=0, FSM in IDLE, all counters 0. Reset mid-frame aborts the frame with no resume; ss goes high immediately.
- Frame format: ADDR_W address bits, then 1 command bit (rw), then DATA_W data bits. Total N = ADDR_W+1+DATA_W sclk periods (17 at defaults).
- Mode 0 timing:
  - mosi changes only while sclk is low.
  - Slave samples on the sclk rising edge.
  - Master samples miso in the clk cycle in which it drives sclk 0->1.
- FSM states: IDLE -> SHIFT -> GAP -> DONE -> IDLE.
- IDLE:
  - busy=0, ss=1, sclk=0.
  - start=1 captures rw, addr and wdata into a shift register and enters SHIFT.
  - start in any other state is ignored (not queued).
- SHIFT:
  - First cycle: ss=0, busy=1, mosi = addr MSB, sclk=0.
  - Half-period counter counts CLK_DIV cycles, then toggles sclk.
  - On each falling toggle, mosi advances to the next bit.
  - After the N-th falling edge: ss=1 and mosi=0 in the same cycle, then go to GAP.
  - ss is low for exactly 2*N*CLK_DIV clk cycles.
- Data phase by command:
  - Write: mosi = wdata bits.
  - Read: mosi held 0 during the data phase; miso sampled on rising edges N-DATA_W+1 .. N into a receive shift register.
- GAP: ss=1, sclk=0 for 2*GAP*CLK_DIV cycles, then DONE.
- DONE (one cycle):
  - done=1 and busy=0.
  - On a read, rdata is updated in this cycle. On a write, rdata is unchanged.
  - Next cycle returns to IDLE.
  - A start seen in the DONE cycle is accepted: busy=0 there, and the FSM goes directly to SHIFT.
- Latency: the first ss-low cycle is T1 (one cycle after the start edge). done is at T1 + 2*N*CLK_DIV + 2*GAP*CLK_DIV, i.e. T1+76 at defaults.
- Counters wrap-free: bit counter 0..N-1; half-period counter 0..CLK_DIV-1 reloads on every toggle.

Optional Feature:
- Macro: SPI_MASTER_LOOPBACK_EN.
- Defined: adds input port lpbk (1 bit).
  - lpbk=1: receive path samples internal mosi instead of miso. ss, sclk and mosi pins still toggle normally.
  - lpbk=0: normal behaviour.
- Undefined: no lpbk port; receive path always samples miso.

Test Plan:
- Reset: hold rst=0 mid-SHIFT, release -> ss=1, sclk=0, busy=0, rdata=0; no done pulse follows.
- Write, rw=1, addr=8'hA5, wdata=8'h3C, defaults -> mosi bits at 17 rising edges = 1010_0101, 1, 0011_1100; ss low for exactly 68 clks; done at T1+76; rdata unchanged.
- Read, rw=0, addr=8'h12, slave model drives miso = 8'hC3 on data-phase edges -> mosi=0 during data phase; rdata=8'hC3 in the done cycle; busy low in the same cycle.
- Back-to-back: start held high through the DONE cycle -> second frame's ss falls on the cycle after done; start pulses while busy=1 produce no extra frame.
- CLK_DIV=1, GAP=1 -> sclk period = 2 clks; ss low 34 clks; done at T1+36.
- SPI_MASTER_LOOPBACK_EN defined, lpbk=1, read addr=8'hFF -> mosi=0 in data phase, so rdata=8'h00; with a write-mode frame forced through the receive path, rdata tracks the wdata bits.
